// File: rtl/eight_to_one_mux_pkg.sv
// Shared constants for the registered 8:1 multiplexer: select width, input
// count and the select code for each data input.
package eight_to_one_mux_pkg;

   localparam int SEL_W      = 3;
   localparam int NUM_INPUTS = 8;

   typedef enum logic [SEL_W-1:0] {
      SEL_A = 3'd0,
      SEL_B = 3'd1,
      SEL_C = 3'd2,
      SEL_D = 3'd3,
      SEL_E = 3'd4,
      SEL_F = 3'd5,
      SEL_G = 3'd6,
      SEL_H = 3'd7
   } sel_e;

endpackage

// File: rtl/eight_to_one_mux_mux8_sel.sv
// Purely combinational 8:1 selector; data_i[k] is returned for select code k.
module mux8_sel
   import eight_to_one_mux_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [NUM_INPUTS-1:0][WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]                 sel_i,
   output logic [WIDTH-1:0]                 data_o
);

   // Every code is decoded explicitly, so no code falls through to an error path.
   always_comb begin
      data_o = '0;
      unique case (sel_e'(sel_i))
         SEL_A: data_o = data_i[0];
         SEL_B: data_o = data_i[1];
         SEL_C: data_o = data_i[2];
         SEL_D: data_o = data_i[3];
         SEL_E: data_o = data_i[4];
         SEL_F: data_o = data_i[5];
         SEL_G: data_o = data_i[6];
         SEL_H: data_o = data_i[7];
      endcase
   end

endmodule

// File: rtl/eight_to_one_mux.sv
// Registered 8:1 mux with one-cycle capture-valid flag. Defining
// EIGHT_TO_ONE_MUX_PARITY_EN adds a registered even-parity output.
module eight_to_one_mux
   import eight_to_one_mux_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] h,
   input  logic [SEL_W-1:0] select,
   input  logic             en,
`ifdef EIGHT_TO_ONE_MUX_PARITY_EN
   output logic             out_parity,
`endif
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   logic [NUM_INPUTS-1:0][WIDTH-1:0] data_w;
   logic [WIDTH-1:0]                 sel_data_w;
   logic [WIDTH-1:0]                 out_q, out_d;
   logic                             valid_q, valid_d;

   assign data_w[0] = a;
   assign data_w[1] = b;
   assign data_w[2] = c;
   assign data_w[3] = d;
   assign data_w[4] = e;
   assign data_w[5] = f;
   assign data_w[6] = g;
   assign data_w[7] = h;

   mux8_sel #(.WIDTH(WIDTH)) u_sel (
      .data_i (data_w),
      .sel_i  (select),
      .data_o (sel_data_w)
   );

   always_comb begin
      out_d   = en ? sel_data_w : out_q;
      valid_d = en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;

`ifdef EIGHT_TO_ONE_MUX_PARITY_EN
   logic parity_q, parity_d;

   // Parity is taken from the selected data, so it lands in the same cycle as out.
   always_comb parity_d = en ? ^sel_data_w : parity_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_q <= 1'b0;
      else     parity_q <= parity_d;
   end

   assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_eight_to_one_mux.sv
// Self-checking bench for eight_to_one_mux: vector table, hand-written
// reset/hold sequences and randomized traffic against a reference model.
module tb_eight_to_one_mux;

   localparam int W = 32;

   logic          clk;
   logic          rst;
   logic [W-1:0]  din [8];
   logic [2:0]    select;
   logic          en;
   logic [W-1:0]  out;
   logic          out_valid;
`ifdef EIGHT_TO_ONE_MUX_PARITY_EN
   logic          out_parity;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_out;
   logic         exp_valid;

   eight_to_one_mux #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .a          (din[0]),
      .b          (din[1]),
      .c          (din[2]),
      .d          (din[3]),
      .e          (din[4]),
      .f          (din[5]),
      .g          (din[6]),
      .h          (din[7]),
      .select     (select),
      .en         (en),
`ifdef EIGHT_TO_ONE_MUX_PARITY_EN
      .out_parity (out_parity),
`endif
      .out        (out),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a_v;
      logic [W-1:0] h_v;
      logic [2:0]   sel;
      logic         en;
      logic [W-1:0] exp_out;
      logic         exp_valid;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   task automatic chk_all(input string name);
      chk({name, ".out"}, out, exp_out);
      chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
`ifdef EIGHT_TO_ONE_MUX_PARITY_EN
      chk({name, ".parity"}, {31'd0, out_parity}, {31'd0, ^exp_out});
`endif
   endtask

   task automatic set_ramp();
      for (int i = 0; i < 8; i++) din[i] = W'(i);
   endtask

   // Reference behaviour: a capture copies the indexed input, otherwise out holds.
   task automatic model_edge();
      if (en) exp_out = din[select];
      exp_valid = en;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) vecs[i] = '{32'd0, 32'd7, 3'(i), 1'b1, W'(i), 1'b1};
      vecs[8]  = '{32'd0, 32'd7, 3'd5, 1'b1, 32'd5, 1'b1};
      vecs[9]  = '{32'd0, 32'd7, 3'd2, 1'b0, 32'd5, 1'b0};
      vecs[10] = '{32'hFFFF_FFFF, 32'h8000_0001, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1};
      vecs[11] = '{32'hFFFF_FFFF, 32'h8000_0001, 3'd7, 1'b1, 32'h8000_0001, 1'b1};
      vecs[12] = '{32'hFFFF_FFFF, 32'h8000_0001, 3'd0, 1'b0, 32'h8000_0001, 1'b0};
      vecs[13] = '{32'd0, 32'd7, 3'd7, 1'b1, 32'd7, 1'b1};
      vecs[14] = '{32'd0, 32'd7, 3'd7, 1'b1, 32'd7, 1'b1};
      vecs[15] = '{32'd0, 32'd7, 3'd6, 1'b1, 32'd6, 1'b1};

      rst = 1'b0; en = 1'b0; select = '0;
      set_ramp();
      #1 rst = 1'b1;
      exp_out = '0; exp_valid = 1'b0;
      #2 chk_all("reset_async");

      // Capture requested while reset is held must be ignored.
      en = 1'b1; select = 3'd4;
      @(posedge clk); #1 chk_all("reset_held_edge");
      @(negedge clk) rst = 1'b0;
      en = 1'b0;
      @(posedge clk); #1 chk_all("post_reset_en0");

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         set_ramp();
         din[0] = vecs[i].a_v;
         din[7] = vecs[i].h_v;
         select = vecs[i].sel;
         en     = vecs[i].en;
         @(posedge clk); #1;
         exp_out = vecs[i].exp_out; exp_valid = vecs[i].exp_valid;
         chk_all($sformatf("vec%0d", i));
      end

      // Inputs wiggling between edges must not reach out (out=6 here).
      for (int k = 0; k < 3; k++) begin
         select = 3'(k + 1); din[k + 1] = 32'hDEAD_0000 + W'(k);
         #1 chk_all($sformatf("midcycle%0d", k));
      end

      // Asynchronous reset between edges, then first capture after release.
      set_ramp();
      rst = 1'b1;
      #1;
      exp_out = '0; exp_valid = 1'b0;
      chk_all("rst_mid_cycle");
      en = 1'b1; select = 3'd6;
      @(posedge clk); #1 chk_all("rst_discard_capture");
      @(negedge clk) rst = 1'b0;
      select = 3'd3;
      @(posedge clk); #1;
      exp_out = 32'd3; exp_valid = 1'b1;
      chk_all("rst_release_capture");

`ifdef EIGHT_TO_ONE_MUX_PARITY_EN
      @(negedge clk) din[3] = 32'h0000_0007; select = 3'd3; en = 1'b1;
      @(posedge clk); #1 chk("parity_d7", {31'd0, out_parity}, 32'd1);
      @(negedge clk) din[2] = 32'h0000_0003; select = 3'd2;
      @(posedge clk); #1 chk("parity_c3", {31'd0, out_parity}, 32'd0);
      exp_out = 32'd3;
`endif

      // Randomized traffic against the reference model.
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) din[i] = $urandom;
         select = 3'($urandom_range(0, 7));
         en     = ($urandom_range(0, 3) != 0);
         model_edge();
         @(posedge clk); #1;
         chk_all($sformatf("rand%0d", n));
         // Scramble after the edge; the model already holds the captured value.
         for (int i = 0; i < 8; i++) din[i] = $urandom;
         select = 3'($urandom_range(0, 7));
         #1 chk_all($sformatf("rand_hold%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/eight_to_one_mux.md
EIGHT_TO_ONE_MUX -- requirements
Module: eight_to_one_mux

Interface
REQ-001 Parameter: WIDTH, default 32, data width of each input and of the output, in bits.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Ports: a, b, c, d, e, f, g, h  input  WIDTH  data inputs 0..7, in select order.
REQ-005 Port: select  input  3  binary index of the input to pass through.
REQ-006 Port: en  input  1  capture enable; a new selection is sampled only when en=1.
REQ-007 Port: out  output  WIDTH  registered selected data.
REQ-008 Port: out_valid  output  1  high for one cycle after each capture.
REQ-009 Port: out_parity  output  1  even parity of out; present only when the REQ-021 macro is defined.

Function
REQ-010 Mapping SHALL be select 0->a, 1->b, 2->c, 3->d, 4->e, 5->f, 6->g, 7->h.
REQ-011 On a rising clk edge with en=1, out SHALL load the selected input and out_valid SHALL go to 1.
REQ-012 Latency SHALL be exactly one clock: inputs and select sampled at edge N appear on out after edge N.
REQ-013 On a rising clk edge with en=0, out SHALL hold its value and out_valid SHALL go to 0.
REQ-014 Changes on select or the data inputs between clock edges SHALL NOT affect out.
REQ-015 All WIDTH bits SHALL pass unmodified, with no truncation, sign extension or arithmetic.
REQ-016 Back-to-back captures with en held at 1 SHALL produce a new result on every cycle, with out_valid held at 1.
REQ-017 All 8 select codes SHALL be legal; there is no default or error path.

Reset
REQ-018 While rst=1, out SHALL be 0, out_valid SHALL be 0 and out_parity (if present) SHALL be 0, independent of clk.
REQ-019 Assertion of rst during operation SHALL clear outputs immediately, without waiting for a clock edge; a pending capture SHALL be discarded.
REQ-020 After rst deasserts, the first capture SHALL occur on the first rising edge with en=1.

Configuration
REQ-021 Macro EIGHT_TO_ONE_MUX_PARITY_EN: when defined, out_parity SHALL exist and equal the XOR of the out bits, registered in the same cycle as out. When undefined, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-022 Shared package eight_to_one_mux_pkg SHALL hold SEL_W=3, NUM_INPUTS=8 and select-code constants SEL_A..SEL_H (0..7).
REQ-023 The combinational 8:1 selector SHALL be a sub-module named mux8_sel, parameterised by WIDTH; the top level adds the output registers, the valid flag and the optional parity logic.

Verification
REQ-024 Drive a..h = 0..7 and en=1, then sweep select 0..7: out[2:0] SHALL equal select one cycle later and out_valid SHALL be 1.
REQ-025 Drive a=32'hFFFF_FFFF, h=32'h8000_0001, and select 0 then 7: out SHALL be 32'hFFFF_FFFF, then 32'h8000_0001, with full width intact.
REQ-026 Capture select=5 (out=5), then set en=0 and change select to 2: out SHALL stay 5 and out_valid SHALL be 0.
REQ-027 With out=6, assert rst between clock edges: out and out_valid SHALL be 0 immediately; after release with select=3 and en=1, out SHALL be 3 after one edge.
REQ-028 With the parity macro defined, capture d=32'h0000_0007: out_parity SHALL be 1; capturing c=32'h0000_0003 SHALL give out_parity 0.
